fetch_unit: RTL

Instruction-fetch sequencer for the single-issue RV32I core. It owns the PC, drives the address of the synchronous instruction ROM, and tracks the ROM's fixed 1-cycle read latency. It buffers returned words in a small skid buffer and hands {pc, inst} to decode over a valid/ready handshake. Execute can redirect it on taken branches and jumps.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_skid_fifo.sv | 68 ++++++
 rtl/fetch_unit.sv | 91 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pkg : shared types and constants for the instruction-fetch slice
// Revision  : 1.0
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int          FETCH_ADDR_W = 32;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;
  localparam int          PC_STEP      = 4;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [31:0]             inst;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_skid_fifo : small circular buffer of {pc, inst} entries with flush
// Revision        : 1.0
// ---------------------------------------------------------------------------
module fetch_skid_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  // Flush outranks push and pop: a redirect voids both in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (push) begin
        r_mem[r_tail] <= push_data;
        r_tail        <= r_tail + 1'b1;
      end
      if (pop) begin
        r_head <= r_head + 1'b1;
      end
      if (push && !pop) begin
        r_count <= r_count + 1'b1;
      end else if (pop && !push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign head  = r_mem[r_head];
  assign count = r_count;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !flush && (r_count == CNT_W'(DEPTH))));

  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(pop && !flush && (r_count == '0)));

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_unit : PC sequencer for a 1-cycle synchronous ROM with skid buffer
// Revision   : 1.0
// ---------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_inst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [31:0]       out_inst
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] r_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;

  logic [ADDR_W-1:0] w_target;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W:0]    w_occ;
  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  fetch_entry_t      w_push_entry;
  fetch_entry_t      w_head;
  logic              w_unused_bits;

  assign w_target      = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign w_unused_bits = ^redirect_pc[1:0];

  assign imem_addr = reset          ? RESET_PC :
                     redirect_valid ? w_target : r_pc;

  assign out_valid = (w_count != '0) & ~redirect_valid;
  assign w_pop     = out_valid & out_ready;

  // Occupancy once this cycle settles; counting the pop keeps 1 instr/cycle.
  assign w_occ   = {1'b0, w_count}
                 + {{CNT_W{1'b0}}, r_inflight}
                 - {{CNT_W{1'b0}}, w_pop};
  assign w_issue = ~reset & (redirect_valid | (w_occ < (CNT_W+1)'(DEPTH)));

  assign w_push            = r_inflight & ~redirect_valid;
  assign w_push_entry.pc   = r_inflight_pc;
  assign w_push_entry.inst = imem_inst;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (w_issue) begin
      r_pc          <= imem_addr + ADDR_W'(PC_STEP);
      r_inflight    <= 1'b1;
      r_inflight_pc <= imem_addr;
    end else begin
      r_inflight    <= 1'b0;
    end
  end

  fetch_skid_fifo #(
    .DEPTH (DEPTH)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count)
  );

  assign out_pc   = w_head.pc;
  assign out_inst = w_head.inst;

endmodule
`default_nettype wire
